// File: rtl/alu_operand_issue.sv
// alu_operand_issue: decodes one RV32I instruction per handshake into an ALU
// opcode plus two operands. A single valid/ready register stage drives the
// ALU inputs directly and carries rd / write-enable / illegal sideband.
module alu_operand_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] oper1,
  output logic [XLEN-1:0] oper2,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLT = 4'd2,  ALU_SLTU = 4'd3,
    ALU_SGE  = 4'd4,  ALU_SGEU = 4'd5,  ALU_AND = 4'd6,  ALU_OR   = 4'd7,
    ALU_XOR  = 4'd8,  ALU_SEQ  = 4'd9,  ALU_SNE = 4'd10, ALU_SL   = 4'd11,
    ALU_SR   = 4'd12, ALU_SRA  = 4'd13
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [XLEN-1:0] i_imm, s_imm, u_imm, shamt;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign i_imm  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign s_imm  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign u_imm  = {in_inst[31:12], 12'b0};
  assign shamt  = {27'b0, in_inst[24:20]};

  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_o1, dec_o2;
  logic [4:0]      dec_rd;
  logic            dec_wen, dec_ill;

  // Instruction decode: opcode/funct fields to ALU opcode, operands, sideband.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    dec_op  = ALU_ADD;
    dec_o1  = '0;
    dec_o2  = '0;
    dec_rd  = '0;
    dec_wen = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_o1  = in_rs1_val;
        dec_o2  = in_rs2_val;
        dec_wen = 1'b1;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: dec_op = ALU_ADD;
            3'd1: dec_op = ALU_SL;
            3'd2: dec_op = ALU_SLT;
            3'd3: dec_op = ALU_SLTU;
            3'd4: dec_op = ALU_XOR;
            3'd5: dec_op = ALU_SR;
            3'd6: dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          dec_op = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          dec_op = ALU_SRA;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_o1  = in_rs1_val;
        dec_o2  = i_imm;
        dec_wen = 1'b1;
        case (funct3)
          3'd0: dec_op = ALU_ADD;
          3'd1: begin
            dec_op = ALU_SL;
            dec_o2 = shamt;
            if (funct7 != 7'h00) dec_ill = 1'b1;
          end
          3'd2: dec_op = ALU_SLT;
          3'd3: dec_op = ALU_SLTU;
          3'd4: dec_op = ALU_XOR;
          3'd5: begin
            dec_o2 = shamt;
            if (funct7 == 7'h00)      dec_op  = ALU_SR;
            else if (funct7 == 7'h20) dec_op  = ALU_SRA;
            else                      dec_ill = 1'b1;
          end
          3'd6: dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec_o2  = u_imm;
        dec_wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec_o1  = in_pc;
        dec_o2  = u_imm;
        dec_wen = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // Link value pc+4 is computed by the ALU itself.
        dec_o1  = in_pc;
        dec_o2  = 32'd4;
        dec_wen = 1'b1;
        if (opcode == OPC_JALR && funct3 != 3'd0) dec_ill = 1'b1;
      end
      OPC_BRANCH: begin
        dec_o1 = in_rs1_val;
        dec_o2 = in_rs2_val;
        case (funct3)
          3'd0: dec_op = ALU_SEQ;
          3'd1: dec_op = ALU_SNE;
          3'd4: dec_op = ALU_SLT;
          3'd5: dec_op = ALU_SGE;
          3'd6: dec_op = ALU_SLTU;
          3'd7: dec_op = ALU_SGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_o1  = in_rs1_val;
        dec_o2  = i_imm;
        dec_wen = 1'b1;
        if (funct3 == 3'd3 || funct3 > 3'd5) dec_ill = 1'b1;
      end
      OPC_STORE: begin
        dec_o1 = in_rs1_val;
        dec_o2 = s_imm;
        if (funct3 > 3'd2) dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase

    if (in_inst[1:0] != 2'b11) dec_ill = 1'b1;

    // Illegal entries travel as a harmless ADD 0,0 with no write-back.
    if (dec_ill) begin
      dec_op  = ALU_ADD;
      dec_o1  = '0;
      dec_o2  = '0;
      dec_wen = 1'b0;
    end else begin
      dec_rd = in_inst[11:7];
      if (dec_rd == 5'd0) dec_wen = 1'b0;
    end
  end

  logic            valid_q, valid_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [XLEN-1:0] oper1_q, oper1_d, oper2_q, oper2_d;
  logic [4:0]      rd_q, rd_d;
  logic            wen_q, wen_d, illegal_q, illegal_d;
  logic            accept;

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Stage next-state: flush beats accept; drain clears valid only.
  always_comb begin
    valid_d   = valid_q;
    alu_op_d  = alu_op_q;
    oper1_d   = oper1_q;
    oper2_d   = oper2_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      alu_op_d  = dec_op;
      oper1_d   = dec_o1;
      oper2_d   = dec_o2;
      rd_d      = dec_rd;
      wen_d     = dec_wen;
      illegal_d = dec_ill;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register with synchronous reset of control and data.
  always_ff @(posedge clk) begin
    // NOTE: the data fields are reset too because the ALU sees them directly
    // and their post-reset value is part of the interface contract.
    if (rst) begin
      valid_q   <= 1'b0;
      alu_op_q  <= '0;
      oper1_q   <= '0;
      oper2_q   <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      valid_q   <= valid_d;
      alu_op_q  <= alu_op_d;
      oper1_q   <= oper1_d;
      oper2_q   <= oper2_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_op      = alu_op_q;
  assign oper1       = oper1_q;
  assign oper2       = oper2_q;
  assign out_rd      = rd_q;
  assign out_wen     = wen_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Scoreboard bench for alu_operand_issue: stimulus pushes hand-computed
// expectations on each accept, a monitor pops and compares on each transfer.
module tb_alu_operand_issue;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0, in_pc = '0, in_rs1_val = '0, in_rs2_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  alu_op;
  logic [31:0] oper1, oper2;
  logic [4:0]  out_rd;
  logic        out_wen, out_illegal;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];

  alu_operand_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .oper1(oper1), .oper2(oper2),
    .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_outputs(input string tag, input exp_t e);
    check({tag, ".alu_op"},  {28'b0, alu_op},     {28'b0, e.op});
    check({tag, ".oper1"},   oper1,               e.o1);
    check({tag, ".oper2"},   oper2,               e.o2);
    check({tag, ".rd"},      {27'b0, out_rd},     {27'b0, e.rd});
    check({tag, ".wen"},     {31'b0, out_wen},    {31'b0, e.wen});
    check({tag, ".illegal"}, {31'b0, out_illegal},{31'b0, e.ill});
  endtask

  function automatic vec_t mkv(input logic [31:0] inst, pc, rs1, rs2,
                               input logic [3:0] op, input logic [31:0] o1, o2,
                               input logic [4:0] rd, input logic wen, ill);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.e.op = op; v.e.o1 = o1; v.e.o2 = o2; v.e.rd = rd; v.e.wen = wen; v.e.ill = ill;
    return v;
  endfunction

  // Present v for one cycle; it is expected to be accepted. exp_ov >= 0 also
  // checks out_valid during that cycle.
  task automatic issue(input vec_t v, input int exp_ov, input string nm);
    in_valid = 1'b1; in_inst = v.inst; in_pc = v.pc;
    in_rs1_val = v.rs1; in_rs2_val = v.rs2;
    @(negedge clk);
    check({nm, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    if (exp_ov >= 0) check({nm, ".out_valid"}, {31'b0, out_valid}, exp_ov[31:0]);
    sb.push_back(v.e);
    @(posedge clk); #1;
  endtask

  task automatic idle_check_valid(input logic exp_v, input string nm);
    in_valid = 1'b0;
    @(negedge clk);
    check(nm, {31'b0, out_valid}, {31'b0, exp_v});
    @(posedge clk); #1;
  endtask

  // Monitor: every transfer on the output side is compared against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_output: got alu_op=%0d oper1=0x%0h, expected no output", alu_op, oper1);
      end else begin
        cmp_outputs("xfer", sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t stream[$];
    vec_t vx, vy, vz, vw, vsub, vsrai;
    exp_t zero_e;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    zero_e = '0;
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.in_ready",  {31'b0, in_ready},  32'd1);
    cmp_outputs("rst", zero_e);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // ADDI x1,x2,-1 with one-cycle latency.
    issue(mkv(32'hFFF10093, 32'h0, 32'd5, 32'd0, 4'd0, 32'd5, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0), 0, "addi");
    idle_check_valid(1'b1, "addi.latency");
    idle_check_valid(1'b0, "addi.drain");

    // SUB then SRAI back to back: no bubble between them.
    vsub  = mkv(32'h402081B3, 32'h0, 32'd10, 32'd3, 4'd1, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0);
    vsrai = mkv(32'h40335293, 32'h0, 32'h80000000, 32'd9, 4'd13, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0);
    issue(vsub, 0, "sub");
    issue(vsrai, 1, "srai");
    idle_check_valid(1'b1, "srai.valid");
    idle_check_valid(1'b0, "srai.drain");

    // Decode table streamed at full rate.
    stream.push_back(mkv(32'h123453B7, 32'h0,    32'hDEAD, 32'hBEEF, 4'd0,  32'h0,    32'h12345000, 5'd7, 1'b1, 1'b0)); // LUI
    stream.push_back(mkv(32'h00208063, 32'h0,    32'h11,   32'h22,   4'd9,  32'h11,   32'h22,       5'd0, 1'b0, 1'b0)); // BEQ
    stream.push_back(mkv(32'hFFFFFFFF, 32'h40,   32'h33,   32'h44,   4'd0,  32'h0,    32'h0,        5'd0, 1'b0, 1'b1)); // bad opcode
    stream.push_back(mkv(32'h00100013, 32'h0,    32'd7,    32'd0,    4'd0,  32'd7,    32'd1,        5'd0, 1'b0, 1'b0)); // ADDI x0
    stream.push_back(mkv(32'h00001217, 32'h1000, 32'h5,    32'h6,    4'd0,  32'h1000, 32'h1000,     5'd4, 1'b1, 1'b0)); // AUIPC
    stream.push_back(mkv(32'h008000EF, 32'h2000, 32'h5,    32'h6,    4'd0,  32'h2000, 32'd4,        5'd1, 1'b1, 1'b0)); // JAL
    stream.push_back(mkv(32'h0020A423, 32'h0,    32'h100,  32'h55,   4'd0,  32'h100,  32'd8,        5'd8, 1'b0, 1'b0)); // SW
    stream.push_back(mkv(32'h0020E063, 32'h0,    32'd1,    32'd2,    4'd3,  32'd1,    32'd2,        5'd0, 1'b0, 1'b0)); // BLTU
    stream.push_back(mkv(32'h0020A063, 32'h0,    32'd1,    32'd2,    4'd0,  32'h0,    32'h0,        5'd0, 1'b0, 1'b1)); // branch f3=2
    stream.push_back(mkv(32'h40331293, 32'h0,    32'd1,    32'd2,    4'd0,  32'h0,    32'h0,        5'd0, 1'b0, 1'b1)); // SLLI bad imm
    stream.push_back(mkv(32'h0020F1B3, 32'h0,    32'hFF00, 32'h0F0F, 4'd6,  32'hFF00, 32'h0F0F,     5'd3, 1'b1, 1'b0)); // AND
    stream.push_back(mkv(32'h00100011, 32'h0,    32'd7,    32'd0,    4'd0,  32'h0,    32'h0,        5'd0, 1'b0, 1'b1)); // inst[1:0]!=3
    stream.push_back(mkv(32'h01F35293, 32'h0,    32'hF0,   32'h0,    4'd12, 32'hF0,   32'd31,       5'd5, 1'b1, 1'b0)); // SRLI 31
    stream.push_back(mkv(32'h00431293, 32'h0,    32'hF0,   32'h0,    4'd11, 32'hF0,   32'd4,        5'd5, 1'b1, 1'b0)); // SLLI 4
    stream.push_back(mkv(32'hFFC12083, 32'h0,    32'h200,  32'h0,    4'd0,  32'h200,  32'hFFFFFFFC, 5'd1, 1'b1, 1'b0)); // LW -4
    foreach (stream[i]) issue(stream[i], -1, $sformatf("stream%0d", i));
    idle_check_valid(1'b1, "stream.last_valid");
    idle_check_valid(1'b0, "stream.drain");

    // Backpressure: held entry stays bit-stable, next one waits.
    vx = mkv(32'h0020C1B3, 32'h0, 32'h0000F0F0, 32'h00000FF0, 4'd8, 32'h0000F0F0, 32'h00000FF0, 5'd3, 1'b1, 1'b0);
    vy = mkv(32'h0020E1B3, 32'h0, 32'h12,       32'h21,       4'd7, 32'h12,       32'h21,       5'd3, 1'b1, 1'b0);
    issue(vx, -1, "bp.x");
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = vy.inst; in_pc = vy.pc;
    in_rs1_val = vy.rs1; in_rs2_val = vy.rs2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp.stall%0d.in_ready", c), {31'b0, in_ready}, 32'd0);
      check($sformatf("bp.stall%0d.out_valid", c), {31'b0, out_valid}, 32'd1);
      cmp_outputs($sformatf("bp.hold%0d", c), vx.e);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(vy, 1, "bp.y");
    idle_check_valid(1'b1, "bp.y_valid");
    idle_check_valid(1'b0, "bp.drain");

    // Flush with a held entry and a waiting instruction: nothing survives.
    vz = mkv(32'h0020B1B3, 32'h0, 32'd4, 32'd5, 4'd3, 32'd4, 32'd5, 5'd3, 1'b1, 1'b0);
    vw = mkv(32'h0020F1B3, 32'h0, 32'd6, 32'd7, 4'd6, 32'd6, 32'd7, 5'd3, 1'b1, 1'b0);
    issue(vz, -1, "fl.z");
    out_ready = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1; in_inst = vw.inst; in_pc = vw.pc;
    in_rs1_val = vw.rs1; in_rs2_val = vw.rs2;
    @(negedge clk);
    check("fl.in_ready", {31'b0, in_ready}, 32'd0);
    check("fl.held_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    void'(sb.pop_front());
    idle_check_valid(1'b0, "fl.out_valid");
    out_ready = 1'b1;
    idle_check_valid(1'b0, "fl.nothing_accepted");

    // Reset during a stall drops the held entry.
    issue(vsub, -1, "rs.sub");
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rs.stalled_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_front());
    @(negedge clk);
    check("rs.out_valid", {31'b0, out_valid}, 32'd0);
    cmp_outputs("rs", zero_e);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Let any remaining transfers retire, bounded.
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    check("sb.drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Producer end of the ALU operand/opcode interface: decodes one RV32I instruction per handshake into alu_op, oper1 and oper2.
- Registers the result in a single valid/ready pipeline stage that drives the ALU inputs directly.
- Sits between register-file read and execute. Also supplies destination-register and write-enable sideband, and flags illegal encodings.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard the held entry and block acceptance this cycle.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_inst  input  32  instruction word.
- in_pc  input  32  instruction address.
- in_rs1_val  input  32  rs1 register value.
- in_rs2_val  input  32  rs2 register value.
- out_valid  output  1  ALU inputs are valid.
- out_ready  input  1  execute stage consumes this cycle.
- alu_op  output  4  ALU opcode.
- oper1  output  32  ALU operand 1.
- oper2  output  32  ALU operand 2; bits [4:0] are the shift amount.
- out_rd  output  5  destination register.
- out_wen  output  1  register write enable.
- out_illegal  output  1  undecodable instruction.

Behaviour:
- ALU opcode encoding (fixed): ADD=0, SUB=1, SLT=2, SLTU=3, SGE=4, SGEU=5, AND=6, OR=7, XOR=8, SEQ=9, SNE=10, SL=11, SR=12, SRA=13. Values 14 and 15 are never emitted.
- Reset: out_valid=0, alu_op=0, oper1=0, oper2=0, out_rd=0, out_wen=0, out_illegal=0. A reset mid-transfer drops the held entry.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready), combinational.
  - Accept when in_valid && in_ready. Outputs appear on the next cycle with out_valid=1 (latency 1).
  - Throughput is one instruction per cycle when out_ready=1.
- Hold: while out_valid && !out_ready, all outputs stay bit-stable.
- Drain: if out_valid && out_ready and there is no accept, out_valid goes to 0 next cycle. Data outputs may hold their stale values.
- Flush: next cycle out_valid=0, regardless of in_valid or out_ready. Flush has priority over accept. Rst has priority over flush.
- Immediates are sign-extended to 32 bits per the RV32I I/S/B/U formats.
- Decode by opcode:
  - OP (0110011): oper1=rs1, oper2=rs2. funct7=0x00 gives ADD/SLL→SL/SLT/SLTU/XOR/SRL→SR/OR/AND. funct7=0x20 gives SUB (funct3 0) or SRA (funct3 5). Any other funct7/funct3 pair is illegal. wen=1.
  - OP-IMM (0010011): oper1=rs1, oper2=I-imm. Same funct3 map; no SUBI.
    - SLLI requires imm[11:5]=0.
    - SRLI/SRAI require imm[11:5]=0x00/0x20; otherwise illegal.
    - For shifts, oper2 = zero-extended imm[4:0].
  - LUI: ADD, oper1=0, oper2=U-imm. wen=1.
  - AUIPC: ADD, oper1=pc, oper2=U-imm. wen=1.
  - JAL/JALR: ADD, oper1=pc, oper2=4 (link value). wen=1. JALR requires funct3=0.
  - BRANCH: oper1=rs1, oper2=rs2. funct3 0/1/4/5/6/7 → SEQ/SNE/SLT/SGE/SLTU/SGEU; 2 and 3 are illegal. wen=0.
  - LOAD (funct3 0,1,2,4,5) and STORE (funct3 0,1,2): ADD, oper1=rs1, oper2=I-imm or S-imm. Load wen=1, store wen=0.
  - Any other opcode, or in_inst[1:0]!=2'b11: illegal.
- Illegal handling: out_illegal=1, alu_op=ADD, oper1=oper2=0, out_wen=0, out_rd=0. The entry still handshakes normally.
- rd handling: out_rd=inst[11:7] for legal instructions. If rd=0, out_wen is forced to 0.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), rs1_val=5 -> next cycle: out_valid=1, alu_op=0, oper1=5, oper2=0xFFFFFFFF, out_rd=1, out_wen=1.
- SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> alu_op=1, oper1=10, oper2=3. SRAI x5,x6,3 (0x40335293) -> alu_op=13, oper2=0x00000003. Both issued back-to-back with out_ready=1 -> consecutive valid cycles, no bubble.
- LUI x7,0x12345 (0x123453B7) -> alu_op=0, oper1=0, oper2=0x12345000, wen=1. BEQ x1,x2 (0x00208063) -> alu_op=9, wen=0.
- Backpressure: accept an instruction, then hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged. On out_ready=1 the second instruction is accepted and appears the following cycle.
- Flush asserted with out_valid=1 and in_valid=1 -> in_ready=0 that cycle; out_valid=0 the next cycle; nothing is accepted.
- Illegal inputs: 0xFFFFFFFF -> out_illegal=1, wen=0, oper1=oper2=0. ADDI x0 (0x00100013) -> out_wen=0, out_illegal=0. Rst mid-stall -> out_valid=0 next cycle.
